// File: rtl/see_vote_monitor.sv
// see_vote_monitor: TMR receive side. Majority-votes three replicas with zero
// latency, flags which replicas disagree with the vote, keeps saturating
// per-replica fault counters and holds one fault report for a valid/ready
// consumer, counting events that arrive while that report is still pending.
module see_vote_monitor #(
   parameter int    W     = 32,
   parameter int    CNT_W = 8,
   parameter string LABEL = "GENERAL"
) (
   input  logic             s_clk_i,
   input  logic             s_resetn_i,
   input  logic             s_en_i,
   input  logic [W-1:0]     s_d_i [3],
   output logic [W-1:0]     s_d_o,
   output logic [2:0]       s_fault_o,
   output logic             s_mfault_o,
   input  logic             s_clr_i,
   output logic [CNT_W-1:0] s_cnt_o [3],
   output logic [CNT_W-1:0] s_lost_o,
   output logic             s_rep_valid_o,
   input  logic             s_rep_ready_i,
   output logic [1:0]       s_rep_idx_o,
   output logic [W-1:0]     s_rep_syn_o
);

   typedef enum logic {
      ST_IDLE,
      ST_PEND
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [W-1:0]     syn_q, syn_d;
   logic [CNT_W-1:0] lost_q, lost_d;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];

   logic [W-1:0]     vote;
   logic [2:0]       fault;
   logic             evt;
   logic             capture;
   logic [1:0]       cap_idx;
   logic [W-1:0]     cap_syn;

   // Bitwise majority vote; each fault flag is a replica that disagrees with it
   always_comb begin
      vote = (s_d_i[0] & s_d_i[1]) | (s_d_i[0] & s_d_i[2]) | (s_d_i[1] & s_d_i[2]);
      for (int i = 0; i < 3; i++) begin
         fault[i] = (s_d_i[i] != vote);
      end
   end

   assign s_d_o      = vote;
   assign s_fault_o  = fault;
   assign s_mfault_o = (fault[0] & fault[1]) | (fault[0] & fault[2]) | (fault[1] & fault[2]);
   assign evt        = s_en_i & (|fault);

   // Report contents for the current cycle's event. Healthy replicas contribute
   // an all-zero term, so the OR of all three syndromes equals d_idx ^ vote for
   // a single fault and the combined syndrome for a multi-replica fault.
   always_comb begin
      case (fault)
         3'b001:  cap_idx = 2'd0;
         3'b010:  cap_idx = 2'd1;
         3'b100:  cap_idx = 2'd2;
         default: cap_idx = 2'd3;
      endcase
      cap_syn = (s_d_i[0] ^ vote) | (s_d_i[1] ^ vote) | (s_d_i[2] ^ vote);
   end

   // Report FSM next state: capture into an idle buffer or a buffer being drained
   // this cycle, otherwise count the event as lost while the report waits.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      syn_d   = syn_q;
      lost_d  = lost_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (evt) begin
               capture = 1'b1;
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (s_rep_ready_i) begin
               if (evt) begin
                  capture = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (evt && (lost_q != CNT_MAX)) begin
               lost_d = lost_q + CNT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (capture) begin
         idx_d = cap_idx;
         syn_d = cap_syn;
      end
      // Clear touches only the statistics, never the FSM or the pending report
      if (s_clr_i) begin
         lost_d = '0;
      end
   end

   // Per-replica saturating fault counters; clear wins over an increment
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s_clr_i) begin
            cnt_d[i] = '0;
         end else if (s_en_i && fault[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // State, report and counter registers with synchronous active-low reset
   always_ff @(posedge s_clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!s_resetn_i) begin
         state_q <= ST_IDLE;
         // NOTE: the report payload is reset too, so idx/syn read as zero
         // after reset rather than holding a stale capture.
         idx_q   <= '0;
         syn_q   <= '0;
         lost_q  <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         syn_q   <= syn_d;
         lost_q  <= lost_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign s_rep_valid_o = (state_q == ST_PEND);
   assign s_rep_idx_o   = idx_q;
   assign s_rep_syn_o   = syn_q;
   assign s_cnt_o       = cnt_q;
   assign s_lost_o      = lost_q;

`ifndef SYNTHESIS
   // Simulation trace of every captured fault event, tagged with the instance label
   always @(posedge s_clk_i) begin
      if (s_resetn_i && capture) begin
         $display("[%s] see event captured: idx=%0d syn=%h", LABEL, cap_idx, cap_syn);
      end
   end
`endif

endmodule

// File: tb/tb_see_vote_monitor.sv
// Directed bench for see_vote_monitor. Reports are checked through a scoreboard:
// the stimulus pushes each expected capture, and a monitor pops and compares on
// every accepted handshake. Counters, flags and the vote are checked directly.
module tb_see_vote_monitor;

   localparam logic [31:0] A5 = 32'h0000_00A5;

   typedef struct packed {
      logic [1:0]  idx;
      logic [31:0] syn;
   } rep_t;

   logic        clk;
   logic        resetn;
   logic        en;
   logic        clr;
   logic        ready;
   logic [31:0] d [3];

   logic [31:0] d_o, d_o2;
   logic [2:0]  fault, fault2;
   logic        mfault, mfault2;
   logic [7:0]  cnt [3];
   logic [7:0]  lost;
   logic [1:0]  cnt2 [3];
   logic [1:0]  lost2;
   logic        valid, valid2;
   logic [1:0]  idx, idx2;
   logic [31:0] syn, syn2;

   rep_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   see_vote_monitor #(.W(32), .CNT_W(8), .LABEL("DUT8")) u_dut (
      .s_clk_i(clk), .s_resetn_i(resetn), .s_en_i(en), .s_d_i(d),
      .s_d_o(d_o), .s_fault_o(fault), .s_mfault_o(mfault), .s_clr_i(clr),
      .s_cnt_o(cnt), .s_lost_o(lost), .s_rep_valid_o(valid),
      .s_rep_ready_i(ready), .s_rep_idx_o(idx), .s_rep_syn_o(syn)
   );

   // Narrow-counter instance sharing the same stimulus, for saturation checks
   see_vote_monitor #(.W(32), .CNT_W(2), .LABEL("DUT2")) u_dut2 (
      .s_clk_i(clk), .s_resetn_i(resetn), .s_en_i(en), .s_d_i(d),
      .s_d_o(d_o2), .s_fault_o(fault2), .s_mfault_o(mfault2), .s_clr_i(clr),
      .s_cnt_o(cnt2), .s_lost_o(lost2), .s_rep_valid_o(valid2),
      .s_rep_ready_i(ready), .s_rep_idx_o(idx2), .s_rep_syn_o(syn2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_d(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      d[0] = a;
      d[1] = b;
      d[2] = c;
      #1;
   endtask

   // Monitor: compare each accepted report against the oldest expected entry
   always @(negedge clk) begin
      if (resetn && valid && ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL report: got idx=%0d syn=%h expected none", idx, syn);
         end else begin
            rep_t e;
            e = sb.pop_front();
            if (idx !== e.idx || syn !== e.syn) begin
               n_err++;
               $display("FAIL report: got idx=%0d syn=%h expected idx=%0d syn=%h",
                        idx, syn, e.idx, e.syn);
            end
         end
      end
   end

   initial begin
      resetn = 1'b0;
      en     = 1'b1;
      clr    = 1'b0;
      ready  = 1'b0;
      set_d(A5, A5, A5);
      tick(2);
      resetn = 1'b1;
      check("reset valid", 32'(valid), 32'd0);
      check("reset idx",   32'(idx),   32'd0);
      check("reset syn",   syn,        32'd0);
      check("reset lost",  32'(lost),  32'd0);

      // 1: all replicas agree
      check("agree vote",  d_o,         A5);
      check("agree fault", 32'(fault),  32'd0);
      tick();
      check("agree valid", 32'(valid),  32'd0);
      check("agree cnt0",  32'(cnt[0]), 32'd0);
      check("agree cnt1",  32'(cnt[1]), 32'd0);
      check("agree cnt2",  32'(cnt[2]), 32'd0);

      // 2: replica 1 upset, no consumer; later events are counted as lost
      set_d(A5, A5 ^ 32'h10, A5);
      check("single vote",   d_o,          A5);
      check("single fault",  32'(fault),   32'b010);
      check("single mfault", 32'(mfault),  32'd0);
      sb.push_back('{idx: 2'd1, syn: 32'h10});
      tick();
      check("single valid",  32'(valid),   32'd1);
      check("single idx",    32'(idx),     32'd1);
      check("single syn",    syn,          32'h10);
      check("single cnt1",   32'(cnt[1]),  32'd1);
      tick(3);
      check("hold cnt1",     32'(cnt[1]),  32'd4);
      check("hold lost",     32'(lost),    32'd3);
      check("hold idx",      32'(idx),     32'd1);
      set_d(A5, A5, A5);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("drain valid",   32'(valid),   32'd0);

      // 3: all three replicas disagree, vote untrusted
      set_d(32'h1, 32'h2, 32'h4);
      check("multi vote",   d_o,         32'h0);
      check("multi fault",  32'(fault),  32'b111);
      check("multi mfault", 32'(mfault), 32'd1);
      sb.push_back('{idx: 2'd3, syn: 32'h7});
      tick();
      check("multi valid",  32'(valid),  32'd1);
      check("multi idx",    32'(idx),    32'd3);
      check("multi syn",    syn,         32'h7);

      // 5: drain and capture in the same cycle, then drain to idle
      set_d(A5 ^ 32'h80, A5, A5);
      ready = 1'b1;
      sb.push_back('{idx: 2'd0, syn: 32'h80});
      tick();
      check("b2b valid", 32'(valid), 32'd1);
      check("b2b idx",   32'(idx),   32'd0);
      check("b2b syn",   syn,        32'h80);
      set_d(A5, A5, A5);
      tick();
      ready = 1'b0;
      check("b2b drain valid", 32'(valid), 32'd0);
      check("b2b cnt0", 32'(cnt[0]), 32'd2);
      check("b2b cnt1", 32'(cnt[1]), 32'd5);
      check("b2b cnt2", 32'(cnt[2]), 32'd1);

      // Disabled monitor: vote and flags still live, nothing counted or captured
      en = 1'b0;
      set_d(A5, A5, A5 ^ 32'h3);
      check("dis fault", 32'(fault), 32'b100);
      tick();
      check("dis valid", 32'(valid),  32'd0);
      check("dis cnt2",  32'(cnt[2]), 32'd1);
      en = 1'b1;

      // Clear wins over increment but still lets the event be captured
      set_d(A5 ^ 32'h1, A5, A5);
      clr = 1'b1;
      sb.push_back('{idx: 2'd0, syn: 32'h1});
      tick();
      clr = 1'b0;
      check("clr cnt0",  32'(cnt[0]), 32'd0);
      check("clr cnt1",  32'(cnt[1]), 32'd0);
      check("clr lost",  32'(lost),   32'd0);
      check("clr valid", 32'(valid),  32'd1);

      // 6: reset while a report is pending
      tick(5);
      check("pre-rst cnt0", 32'(cnt[0]), 32'd5);
      resetn = 1'b0;
      #1;
      check("rst comb vote", d_o, A5);
      tick();
      check("rst valid", 32'(valid),  32'd0);
      check("rst cnt0",  32'(cnt[0]), 32'd0);
      check("rst lost",  32'(lost),   32'd0);
      check("rst syn",   syn,         32'd0);
      resetn = 1'b1;
      void'(sb.pop_back());

      // 4: replica 2 faulty for six cycles; two-bit counters saturate at 3
      set_d(A5, A5, A5 ^ 32'h0F00);
      sb.push_back('{idx: 2'd2, syn: 32'h0F00});
      tick(6);
      check("sat cnt2 narrow", 32'(cnt2[2]), 32'd3);
      check("sat lost narrow", 32'(lost2),   32'd3);
      check("sat cnt2 wide",   32'(cnt[2]),  32'd6);
      check("sat lost wide",   32'(lost),    32'd5);
      set_d(A5, A5, A5);
      clr   = 1'b1;
      ready = 1'b1;
      tick();
      clr   = 1'b0;
      ready = 1'b0;
      check("sat clr narrow", 32'(cnt2[2]), 32'd0);
      check("sat clr valid",  32'(valid),   32'd0);

      check("scoreboard empty", 32'(sb.size()), 32'd0);
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
